time_counter_mc: RTL and testbench
==================================

Name: time_counter_mc

Overview:
- Parametrised, multi-channel successor to the single millisecond counter.
- Each of NCH independent channels accumulates a shared tick pulse (e.g. the 1 ms strobe) while running.
- Per channel: start/stop/clear control, lap capture, and selectable wrap or saturate overflow handling.
- Sits between the tick generator and the display/readout logic of the time-measurement circuit.

Parameters:
- NCH, 4: number of independent channels (1..16).
- WIDTH, 32: counter width per channel, in bits (8..32).
- SATURATE, 0: overflow mode. 0 = wrap to 0 on overflow; 1 = hold at 2^WIDTH-1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- tick  input  1  single-cycle strobe, one per time unit; shared by all channels.
- start  input  NCH  per-channel start/resume request, sampled each cycle.
- stop  input  NCH  per-channel pause request.
- clear  input  NCH  per-channel clear request; returns the channel to IDLE.
- lap  input  NCH  per-channel lap-capture request.
- count  output  NCH*WIDTH  live counter values; channel i occupies bits [i*WIDTH +: WIDTH].
- lap_val  output  NCH*WIDTH  last captured lap value per channel.
- lap_valid  output  NCH  one-cycle pulse when lap_val[i] updates.
- running  output  NCH  1 while channel i is in RUN.
- ovf  output  NCH  sticky overflow flag per channel.

Behaviour:
- Reset: rst low asynchronously forces the following, independent of clk:
  - every channel to IDLE;
  - count, lap_val, lap_valid, running and ovf all to 0.
- Channel FSM states: IDLE (count = 0), RUN, HOLD.
  - IDLE: start -> RUN.
  - RUN: stop -> HOLD.
  - HOLD: start -> RUN.
  - Any state: clear -> IDLE.
- Input priority within one channel: clear > stop > start.
  - start and stop together in RUN -> HOLD.
  - start and stop together in HOLD -> RUN.
- Increment rule: count increments at a rising edge when the registered state is RUN and tick = 1.
  - stop asserted on a tick cycle: that tick is still counted.
  - start asserted on a tick cycle: that tick is not counted.
  - clear on a tick cycle: count = 0 and the tick is lost.
- Latency: count shows the new value one clock after the tick cycle. running follows the registered state, so it changes one clock after start/stop.
- tick held high counts once per clk cycle; no edge detection is performed.
- Overflow, when a tick arrives at count = 2^WIDTH-1 in RUN:
  - SATURATE=0: count -> 0, ovf <= 1.
  - SATURATE=1: count holds at the maximum, ovf <= 1.
  - In both modes ovf stays set until clear or reset.
- Lap capture:
  - lap = 1 in RUN or HOLD: lap_val[i] <= the pre-update count; lap_valid[i] = 1 on the next cycle, for one cycle only.
  - lap in IDLE: ignored, no lap_valid pulse.
  - lap together with clear: the capture still uses the pre-clear value and lap_valid pulses.
  - lap held high for k cycles: k captures and k consecutive lap_valid pulses.
- clear does not alter lap_val; lap_val is only reset by rst.
- Channels are fully independent. Simultaneous events on different channels never interact.
- All arithmetic is unsigned, modulo 2^WIDTH. There are no combinational paths from inputs to outputs.

Decomposition:
- Package time_cnt_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_HOLD=2'd2 (2'd3 is illegal and recovers to IDLE);
  - the function computing the per-channel slice offset.
- Sub-module time_chan implements one channel: FSM, counter, overflow logic and lap register, parametrised by WIDTH and SATURATE.
- The top level is a generate loop of NCH time_chan instances plus output packing.

Test Plan:
- Reset mid-run: channel 0 in RUN at count=57, pulse rst low between clock edges -> all outputs read 0 immediately, before the next clk edge.
- Basic count: start[0], then 10 ticks, then stop[0] coinciding with the 11th tick, then 5 more ticks -> count[0]=11 and running[0]=0; resume with start[0] and 3 ticks -> count[0]=14.
- Wrap vs saturate: WIDTH=8, channel in RUN at 255, one tick:
  - SATURATE=0 -> count=0, ovf=1;
  - SATURATE=1 -> count=255, ovf=1;
  - clear -> ovf=0, count=0.
- Lap: RUN at count=20, lap[1] on a tick cycle -> lap_val[1]=20, count=21 and lap_valid[1] high for exactly one cycle; lap in IDLE -> no pulse.
- Priority: clear, stop and start asserted together on channel 2 in RUN at count=9 -> IDLE, count=0; stop+start in HOLD -> RUN.
- Independence: NCH=4 with channels started on staggered cycles, 100 ticks, then channel 3 cleared -> channels 0..2 hold their distinct expected counts and channel 3 reads 0.

Source files
------------

// File: rtl/time_cnt_pkg.sv
// rtl/time_cnt_pkg.sv - shared channel state encoding and slice helper for time_counter_mc
package time_cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HOLD    = 2'd2,
    ST_ILLEGAL = 2'd3
  } chan_state_e;

  // Bit offset of channel ch inside a packed NCH*width bus.
  function automatic int chan_offset(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/time_chan.sv
// rtl/time_chan.sv - one timer channel: run/hold FSM, tick counter, overflow flag, lap register
module time_chan
  import time_cnt_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_clear,
  input  logic             i_lap,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_lap_val,
  output logic             o_lap_valid,
  output logic             o_running,
  output logic             o_ovf
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  chan_state_e      r_state;
  chan_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_lap_val;
  logic             r_lap_valid;
  logic             r_ovf;
  logic             w_inc;
  logic             w_at_max;
  logic             w_lap_take;

  // Counting keys off the registered state, so a start on a tick cycle misses that tick.
  assign w_inc      = (r_state == ST_RUN) && i_tick;
  assign w_at_max   = (r_count == CNT_MAX);
  assign w_lap_take = i_lap && ((r_state == ST_RUN) || (r_state == ST_HOLD));

  always_comb begin
    w_state_nxt = r_state;
    if (i_clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: if (i_start) w_state_nxt = ST_RUN;
        ST_RUN:  if (i_stop)  w_state_nxt = ST_HOLD;
        ST_HOLD: if (i_start) w_state_nxt = ST_RUN;
        default:              w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_lap_val   <= '0;
      r_lap_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lap_valid <= w_lap_take;
      if (w_lap_take) begin
        r_lap_val <= r_count;
      end
      if (i_clear) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (w_inc) begin
        if (w_at_max) begin
          r_ovf <= 1'b1;
          if (!SATURATE) begin
            r_count <= '0;
          end
        end else begin
          r_count <= r_count + CNT_ONE;
        end
      end
    end
  end

  assign o_count     = r_count;
  assign o_lap_val   = r_lap_val;
  assign o_lap_valid = r_lap_valid;
  assign o_running   = (r_state == ST_RUN);
  assign o_ovf       = r_ovf;

endmodule

// File: rtl/time_counter_mc.sv
// rtl/time_counter_mc.sv - NCH independent tick-accumulating timer channels with packed outputs
module time_counter_mc
  import time_cnt_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [NCH-1:0]       start,
  input  logic [NCH-1:0]       stop,
  input  logic [NCH-1:0]       clear,
  input  logic [NCH-1:0]       lap,
  output logic [NCH*WIDTH-1:0] count,
  output logic [NCH*WIDTH-1:0] lap_val,
  output logic [NCH-1:0]       lap_valid,
  output logic [NCH-1:0]       running,
  output logic [NCH-1:0]       ovf
);

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    localparam int OFS = chan_offset(g, WIDTH);

    time_chan #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_chan (
      .i_clk       (clk),
      .i_rst_n     (rst),
      .i_tick      (tick),
      .i_start     (start[g]),
      .i_stop      (stop[g]),
      .i_clear     (clear[g]),
      .i_lap       (lap[g]),
      .o_count     (count[OFS +: WIDTH]),
      .o_lap_val   (lap_val[OFS +: WIDTH]),
      .o_lap_valid (lap_valid[g]),
      .o_running   (running[g]),
      .o_ovf       (ovf[g])
    );
  end

endmodule

// File: tb/tb_time_counter_mc.sv
// tb/tb_time_counter_mc.sv - scoreboard bench for time_counter_mc, wrap and saturate builds side by side
module tb_time_counter_mc;

  localparam int NCH  = 4;
  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           tick  = 1'b0;
  logic [NCH-1:0] start = '0;
  logic [NCH-1:0] stop  = '0;
  logic [NCH-1:0] clear = '0;
  logic [NCH-1:0] lap   = '0;

  logic [NCH*W-1:0] cnt0, lv0, cnt1, lv1;
  logic [NCH-1:0]   lvv0, run0, ovf0, lvv1, run1, ovf1;

  typedef struct packed {
    logic [NCH*W-1:0] cnt;
    logic [NCH*W-1:0] lv;
    logic [NCH-1:0]   lvv;
    logic [NCH-1:0]   run;
    logic [NCH-1:0]   ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  int n_cmp = 0;
  int n_bad = 0;

  int m_cnt   [2][NCH];
  int m_lv    [2][NCH];
  bit m_lvv   [2][NCH];
  bit m_ovf   [2][NCH];
  bit m_active[2][NCH];
  bit m_run   [2][NCH];

  time_counter_mc #(.NCH(NCH), .WIDTH(W), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst_n), .tick(tick), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .count(cnt0), .lap_val(lv0), .lap_valid(lvv0), .running(run0), .ovf(ovf0)
  );

  time_counter_mc #(.NCH(NCH), .WIDTH(W), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst_n), .tick(tick), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .count(cnt1), .lap_val(lv1), .lap_valid(lvv1), .running(run1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++) begin
        m_cnt[d][c] = 0; m_lv[d][c] = 0; m_lvv[d][c] = 0;
        m_ovf[d][c] = 0; m_active[d][c] = 0; m_run[d][c] = 0;
      end
  endtask

  // Stopwatch semantics: active = started since last clear, run = currently accumulating.
  task automatic model_step(input bit t, input logic [NCH-1:0] s, p, c, l);
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < NCH; ch++) begin
        m_lvv[d][ch] = 0;
        if (l[ch] && m_active[d][ch]) begin
          m_lv[d][ch]  = m_cnt[d][ch];
          m_lvv[d][ch] = 1;
        end
        if (c[ch]) begin
          m_cnt[d][ch] = 0; m_ovf[d][ch] = 0; m_active[d][ch] = 0; m_run[d][ch] = 0;
        end else begin
          if (m_run[d][ch] && t) begin
            if (m_cnt[d][ch] == MAXV) begin
              m_ovf[d][ch] = 1;
              m_cnt[d][ch] = (d == 1) ? MAXV : 0;
            end else begin
              m_cnt[d][ch] = m_cnt[d][ch] + 1;
            end
          end
          if (!m_active[d][ch]) begin
            if (s[ch]) begin m_active[d][ch] = 1; m_run[d][ch] = 1; end
          end else if (m_run[d][ch]) begin
            if (p[ch]) m_run[d][ch] = 0;
          end else if (s[ch]) begin
            m_run[d][ch] = 1;
          end
        end
      end
  endtask

  function automatic exp_t pack(input int d);
    exp_t e;
    e = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      e.cnt[ch*W +: W] = W'(m_cnt[d][ch]);
      e.lv[ch*W +: W]  = W'(m_lv[d][ch]);
      e.lvv[ch] = m_lvv[d][ch];
      e.run[ch] = m_run[d][ch];
      e.ovf[ch] = m_ovf[d][ch];
    end
    return e;
  endfunction

  task automatic cycle(input bit t, input logic [NCH-1:0] s, p, c, l);
    @(negedge clk);
    tick = t; start = s; stop = p; clear = c; lap = l;
    model_step(t, s, p, c, l);
    q0.push_back(pack(0));
    q1.push_back(pack(1));
  endtask

  task automatic settle();
    cycle(1'b0, '0, '0, '0, '0);
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_cnt0"}, cnt0, 32'd0);
    chk({nm, "_lv0"},  lv0,  32'd0);
    chk({nm, "_flg0"}, 32'({lvv0, run0, ovf0}), 32'd0);
    chk({nm, "_cnt1"}, cnt1, 32'd0);
    chk({nm, "_lv1"},  lv1,  32'd0);
    chk({nm, "_flg1"}, 32'({lvv1, run1, ovf1}), 32'd0);
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && q0.size() != 0 && q1.size() != 0) begin
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      chk("sb_wrap_count",   cnt0, e0.cnt);
      chk("sb_wrap_lapval",  lv0,  e0.lv);
      chk("sb_wrap_lapvld",  32'(lvv0), 32'(e0.lvv));
      chk("sb_wrap_running", 32'(run0), 32'(e0.run));
      chk("sb_wrap_ovf",     32'(ovf0), 32'(e0.ovf));
      chk("sb_sat_count",    cnt1, e1.cnt);
      chk("sb_sat_lapval",   lv1,  e1.lv);
      chk("sb_sat_lapvld",   32'(lvv1), 32'(e1.lvv));
      chk("sb_sat_running",  32'(run1), 32'(e1.run));
      chk("sb_sat_ovf",      32'(ovf1), 32'(e1.ovf));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk_all_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // Channel 0 to 57, then an asynchronous reset between clock edges.
    cycle(1'b0, 4'b0001, '0, '0, '0);
    repeat (57) cycle(1'b1, '0, '0, '0, '0);
    settle();
    chk("pre_reset_cnt", 32'(cnt0[0 +: W]), 32'd57);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    model_reset();
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Basic count, stop on the 11th tick, then resume.
    cycle(1'b0, 4'b0001, '0, '0, '0);
    repeat (10) cycle(1'b1, '0, '0, '0, '0);
    cycle(1'b1, '0, 4'b0001, '0, '0);
    repeat (5) cycle(1'b1, '0, '0, '0, '0);
    settle();
    chk("basic_cnt11", 32'(cnt0[0 +: W]), 32'd11);
    chk("basic_stopped", 32'(run0[0]), 32'd0);
    cycle(1'b0, 4'b0001, '0, '0, '0);
    repeat (3) cycle(1'b1, '0, '0, '0, '0);
    settle();
    chk("basic_cnt14", 32'(cnt0[0 +: W]), 32'd14);

    // Priority on channel 2.
    cycle(1'b0, 4'b0100, '0, '0, '0);
    repeat (9) cycle(1'b1, '0, '0, '0, '0);
    cycle(1'b1, 4'b0100, 4'b0100, 4'b0100, '0);
    @(posedge clk);
    #2;
    chk("prio_cnt", 32'(cnt0[2*W +: W]), 32'd0);
    chk("prio_idle", 32'(run0[2]), 32'd0);
    cycle(1'b0, 4'b0100, '0, '0, '0);
    cycle(1'b0, '0, 4'b0100, '0, '0);
    cycle(1'b0, 4'b0100, 4'b0100, '0, '0);
    @(posedge clk);
    #2;
    chk("hold_startstop_run", 32'(run0[2]), 32'd1);

    // Lap on channel 1.
    cycle(1'b0, 4'b0010, '0, '0, '0);
    repeat (20) cycle(1'b1, '0, '0, '0, '0);
    cycle(1'b1, '0, '0, '0, 4'b0010);
    @(posedge clk);
    #2;
    chk("lap_val20", 32'(lv0[W +: W]), 32'd20);
    chk("lap_cnt21", 32'(cnt0[W +: W]), 32'd21);
    chk("lap_pulse", 32'(lvv0[1]), 32'd1);
    cycle(1'b0, '0, '0, '0, '0);
    @(posedge clk);
    #2;
    chk("lap_pulse_end", 32'(lvv0[1]), 32'd0);
    cycle(1'b0, '0, '0, 4'b0010, '0);
    cycle(1'b0, '0, '0, '0, 4'b0010);
    @(posedge clk);
    #2;
    chk("lap_idle_nopulse", 32'(lvv0[1]), 32'd0);
    chk("lap_kept_on_clear", 32'(lv0[W +: W]), 32'd20);

    // Overflow on channel 3.
    cycle(1'b0, 4'b1000, '0, '0, '0);
    repeat (MAXV) cycle(1'b1, '0, '0, '0, '0);
    @(posedge clk);
    #2;
    chk("at_max_wrap", 32'(cnt0[3*W +: W]), 32'(MAXV));
    chk("at_max_sat",  32'(cnt1[3*W +: W]), 32'(MAXV));
    cycle(1'b1, '0, '0, '0, '0);
    @(posedge clk);
    #2;
    chk("wrap_cnt", 32'(cnt0[3*W +: W]), 32'd0);
    chk("wrap_ovf", 32'(ovf0[3]), 32'd1);
    chk("sat_cnt",  32'(cnt1[3*W +: W]), 32'(MAXV));
    chk("sat_ovf",  32'(ovf1[3]), 32'd1);
    cycle(1'b0, '0, '0, 4'b1000, '0);
    @(posedge clk);
    #2;
    chk("clr_ovf_wrap", 32'(ovf0[3]), 32'd0);
    chk("clr_ovf_sat",  32'(ovf1[3]), 32'd0);
    chk("clr_cnt_sat",  32'(cnt1[3*W +: W]), 32'd0);

    // Staggered starts, 100 ticks, clear channel 3.
    cycle(1'b0, '0, '0, 4'b1111, '0);
    cycle(1'b1, 4'b0001, '0, '0, '0);
    cycle(1'b1, 4'b0010, '0, '0, '0);
    cycle(1'b1, 4'b0100, '0, '0, '0);
    cycle(1'b1, 4'b1000, '0, '0, '0);
    repeat (100) cycle(1'b1, '0, '0, '0, '0);
    cycle(1'b0, '0, '0, 4'b1000, '0);
    @(posedge clk);
    #2;
    chk("indep_ch0", 32'(cnt0[0 +: W]),   32'd103);
    chk("indep_ch1", 32'(cnt0[W +: W]),   32'd102);
    chk("indep_ch2", 32'(cnt0[2*W +: W]), 32'd101);
    chk("indep_ch3", 32'(cnt0[3*W +: W]), 32'd0);

    // Random traffic; clears only in the last 50 cycles of every 500.
    for (int i = 0; i < 3000; i++) begin
      logic [NCH-1:0] s, p, c, l;
      bit t;
      t = ($urandom_range(3) != 0);
      for (int b = 0; b < NCH; b++) begin
        s[b] = ($urandom_range(3) == 0);
        p[b] = ($urandom_range(7) == 0);
        c[b] = ((i % 500) >= 450) && ($urandom_range(15) == 0);
        l[b] = ($urandom_range(7) == 0);
      end
      cycle(t, s, p, c, l);
    end
    settle();
    chk("queue_drained", 32'(q0.size() + q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
